comb_stim_gen: RTL and testbench

- Synchronous stimulus sequencer that sits directly upstream of the comb_str mux.
- Drives its data inputs A, B, C, D and its select sel with a counting pattern: a 4-bit count on {A,B,C,D}, and sel switching from 0 to 1 at a programmed vector index.
- Replaces the free-running initial-block stimulus with a clocked, startable, pausable source.
- Usable in RTL self-test wrappers and in benches.

---
 rtl/comb_stim_gen_pkg.sv | 13 +
 rtl/comb_stim_gen_step_div.sv | 34 +++
 rtl/comb_stim_gen.sv | 137 +++++++++++++
 tb/tb_comb_stim_gen.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/comb_stim_gen_pkg.sv
// Shared definitions for the comb_str stimulus sequencer: FSM encoding and
// the width of the counting pattern driven onto {A,B,C,D}.
package comb_stim_gen_pkg;

  localparam int PAT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : comb_stim_gen_pkg

// File: rtl/comb_stim_gen_step_div.sv
// Step divider: emits a one-cycle step every STEP_DIV enabled cycles. When
// en is low the count freezes, so a paused vector keeps whatever part of its
// hold time it has not used yet.
module stim_step_div #(
  parameter int STEP_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic step
);

  localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DIV_W-1:0] LAST = DIV_W'(STEP_DIV - 1);

  logic [DIV_W-1:0] cnt_q;

  // The step is decoded from the registered count, so it falls on the last
  // cycle of each hold window.
  assign step = en && (cnt_q == LAST);

  // Divider count: clears on reset, on a run start, and on every step.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so that every
    // always_ff block samples the values from before the clock edge.
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= step ? '0 : cnt_q + 1'b1;
    end
  end

endmodule : stim_step_div

// File: rtl/comb_stim_gen.sv
// Clocked stimulus source for the comb_str mux. Presents a 4-bit counting
// pattern on {A,B,C,D}, raises sel from vector SEL_SWITCH onward, and can be
// started and paused. Every output comes straight from a register.
module comb_stim_gen
  import comb_stim_gen_pkg::*;
#(
  parameter int NUM_VEC    = 101,
  parameter int SEL_SWITCH = 25,
  parameter int STEP_DIV   = 1,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             hold,
  output logic             A,
  output logic             B,
  output logic             C,
  output logic             D,
  output logic             sel,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] vec_idx
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VEC - 1);

  state_e             state_q, state_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic               sel_q, sel_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               div_clr, div_en, step;

  stim_step_div #(
    .STEP_DIV (STEP_DIV)
  ) u_step_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (div_clr),
    .en   (div_en),
    .step (step)
  );

  // Next-state and next-output decode for the IDLE/RUN/DONE sequencer.
  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d = state_q;
    pat_d   = pat_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    div_clr = 1'b0;
    div_en  = 1'b0;

    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        if (start) begin
          state_d = RUN;
          idx_d   = '0;
          pat_d   = '0;
          sel_d   = (SEL_SWITCH == 0);
          valid_d = 1'b1;
          busy_d  = 1'b1;
          div_clr = 1'b1;
        end
      end
      RUN: begin
        div_en = !hold;
        if (step) begin
          if (idx_q == LAST_IDX) begin
            // Last vector finished: pattern, sel and index stay on it.
            state_d = DONE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
            pat_d = pat_q + 1'b1;
            sel_d = (int'(idx_q) + 1 >= SEL_SWITCH);
          end
        end
      end
      DONE: begin
        // One-cycle completion state; start is not looked at here.
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset wins over everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      idx_q   <= '0;
      sel_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign A       = pat_q[3];
  assign B       = pat_q[2];
  assign C       = pat_q[1];
  assign D       = pat_q[0];
  assign sel     = sel_q;
  assign valid   = valid_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign vec_idx = idx_q;

endmodule : comb_stim_gen

// File: tb/tb_comb_stim_gen.sv
// Directed bench for comb_stim_gen. Four instances cover the default
// configuration, a slow divider with hold, a single-vector run and a run
// where sel never asserts. Each instance's outputs are packed into one word
// {vec_idx, A,B,C,D, sel, valid, busy, done} for comparison.
module tb_comb_stim_gen;

  logic clk = 1'b0;
  logic rst;
  logic start_def, start_div, start_one, start_nos;
  logic hold_def, hold_div, hold_one, hold_nos;

  logic       a_def, b_def, c_def, d_def, sel_def, valid_def, busy_def, done_def;
  logic [7:0] idx_def;
  logic       a_div, b_div, c_div, d_div, sel_div, valid_div, busy_div, done_div;
  logic [7:0] idx_div;
  logic       a_one, b_one, c_one, d_one, sel_one, valid_one, busy_one, done_one;
  logic [7:0] idx_one;
  logic       a_nos, b_nos, c_nos, d_nos, sel_nos, valid_nos, busy_nos, done_nos;
  logic [7:0] idx_nos;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  comb_stim_gen dut_def (
    .clk(clk), .rst(rst), .start(start_def), .hold(hold_def),
    .A(a_def), .B(b_def), .C(c_def), .D(d_def), .sel(sel_def),
    .valid(valid_def), .busy(busy_def), .done(done_def), .vec_idx(idx_def)
  );

  comb_stim_gen #(.NUM_VEC(4), .STEP_DIV(3)) dut_div (
    .clk(clk), .rst(rst), .start(start_div), .hold(hold_div),
    .A(a_div), .B(b_div), .C(c_div), .D(d_div), .sel(sel_div),
    .valid(valid_div), .busy(busy_div), .done(done_div), .vec_idx(idx_div)
  );

  comb_stim_gen #(.NUM_VEC(1), .SEL_SWITCH(0)) dut_one (
    .clk(clk), .rst(rst), .start(start_one), .hold(hold_one),
    .A(a_one), .B(b_one), .C(c_one), .D(d_one), .sel(sel_one),
    .valid(valid_one), .busy(busy_one), .done(done_one), .vec_idx(idx_one)
  );

  comb_stim_gen #(.SEL_SWITCH(200)) dut_nos (
    .clk(clk), .rst(rst), .start(start_nos), .hold(hold_nos),
    .A(a_nos), .B(b_nos), .C(c_nos), .D(d_nos), .sel(sel_nos),
    .valid(valid_nos), .busy(busy_nos), .done(done_nos), .vec_idx(idx_nos)
  );

  wire [15:0] obs_def = {idx_def, a_def, b_def, c_def, d_def, sel_def, valid_def, busy_def, done_def};
  wire [15:0] obs_div = {idx_div, a_div, b_div, c_div, d_div, sel_div, valid_div, busy_div, done_div};
  wire [15:0] obs_one = {idx_one, a_one, b_one, c_one, d_one, sel_one, valid_one, busy_one, done_one};
  wire [15:0] obs_nos = {idx_nos, a_nos, b_nos, c_nos, d_nos, sel_nos, valid_nos, busy_nos, done_nos};

  // Expected output word for vector idx; the pattern is always idx mod 16.
  function automatic logic [15:0] exp_v(input int idx, input bit s,
                                        input bit v, input bit b, input bit d);
    logic [7:0] i8;
    i8 = 8'(idx);
    return {i8, i8[3:0], s, v, b, d};
  endfunction

  // Advance one clock; inputs are driven and outputs sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    tests_run++;
    if (obs_def !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_def: got %h want %h", obs_def, 16'h0000);
    end
    tests_run++;
    if (obs_div !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_div: got %h want %h", obs_div, 16'h0000);
    end
    tests_run++;
    if (obs_one !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_one: got %h want %h", obs_one, 16'h0000);
    end
    tests_run++;
    if (obs_nos !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_nos: got %h want %h", obs_nos, 16'h0000);
    end
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      tests_run++;
      if (obs_def !== 16'h0000) begin
        tests_failed++;
        $display("FAIL idle_after_reset cyc %0d: got %h want %h", c, obs_def, 16'h0000);
      end
    end
  endtask

  task automatic test_default_run();
    start_def = 1'b1;
    tick();
    start_def = 1'b0;
    for (int i = 0; i <= 100; i++) begin
      tests_run++;
      if (obs_def !== exp_v(i, i >= 25, 1, 1, 0)) begin
        tests_failed++;
        $display("FAIL default_run vec %0d: got %h want %h", i, obs_def, exp_v(i, i >= 25, 1, 1, 0));
      end
      tick();
    end
    tests_run++;
    if (obs_def !== exp_v(100, 1, 0, 0, 1)) begin
      tests_failed++;
      $display("FAIL default_done: got %h want %h", obs_def, exp_v(100, 1, 0, 0, 1));
    end
    tick();
    tests_run++;
    if (obs_def !== exp_v(100, 1, 0, 0, 0)) begin
      tests_failed++;
      $display("FAIL default_idle_after_done: got %h want %h", obs_def, exp_v(100, 1, 0, 0, 0));
    end
  endtask

  task automatic test_hold_div();
    int run_cycles;
    int e;
    run_cycles = 0;
    start_div = 1'b1;
    tick();
    start_div = 1'b0;
    // Vector 1 starts at cycle 3; hold covers cycles 3..7, so vector 1
    // stays up for cycles 3..10 and the run spans 17 cycles.
    for (int c = 0; c < 17; c++) begin
      e = (c < 3) ? 0 : (c < 11) ? 1 : (c < 14) ? 2 : 3;
      hold_div = (c >= 3 && c < 8);
      if (busy_div === 1'b1) run_cycles++;
      tests_run++;
      if (obs_div !== exp_v(e, 0, 1, 1, 0)) begin
        tests_failed++;
        $display("FAIL hold_div cyc %0d: got %h want %h", c, obs_div, exp_v(e, 0, 1, 1, 0));
      end
      tick();
    end
    hold_div = 1'b0;
    tests_run++;
    if (obs_div !== exp_v(3, 0, 0, 0, 1)) begin
      tests_failed++;
      $display("FAIL hold_div_done: got %h want %h", obs_div, exp_v(3, 0, 0, 0, 1));
    end
    tests_run++;
    if (run_cycles !== 17) begin
      tests_failed++;
      $display("FAIL hold_div_run_cycles: got %0d want %0d", run_cycles, 17);
    end
    tick();
    tests_run++;
    if (obs_div !== exp_v(3, 0, 0, 0, 0)) begin
      tests_failed++;
      $display("FAIL hold_div_idle: got %h want %h", obs_div, exp_v(3, 0, 0, 0, 0));
    end
  endtask

  task automatic test_start_and_restart();
    start_def = 1'b1;
    tick();
    start_def = 1'b0;
    for (int i = 0; i <= 100; i++) begin
      tests_run++;
      if (obs_def !== exp_v(i, i >= 25, 1, 1, 0)) begin
        tests_failed++;
        $display("FAIL start_mid_run vec %0d: got %h want %h", i, obs_def, exp_v(i, i >= 25, 1, 1, 0));
      end
      start_def = (i == 50) || (i == 100);
      tick();
    end
    tests_run++;
    if (obs_def !== exp_v(100, 1, 0, 0, 1)) begin
      tests_failed++;
      $display("FAIL restart_done: got %h want %h", obs_def, exp_v(100, 1, 0, 0, 1));
    end
    tick();
    tests_run++;
    if (obs_def !== exp_v(100, 1, 0, 0, 0)) begin
      tests_failed++;
      $display("FAIL restart_idle: got %h want %h", obs_def, exp_v(100, 1, 0, 0, 0));
    end
    tick();
    start_def = 1'b0;
    tests_run++;
    if (obs_def !== exp_v(0, 0, 1, 1, 0)) begin
      tests_failed++;
      $display("FAIL restart_vec0: got %h want %h", obs_def, exp_v(0, 0, 1, 1, 0));
    end
    tick();
    tests_run++;
    if (obs_def !== exp_v(1, 0, 1, 1, 0)) begin
      tests_failed++;
      $display("FAIL restart_vec1: got %h want %h", obs_def, exp_v(1, 0, 1, 1, 0));
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    start_def = 1'b1;
    tick();
    start_def = 1'b0;
    for (int i = 0; i <= 40; i++) begin
      tests_run++;
      if (obs_def !== exp_v(i, i >= 25, 1, 1, 0)) begin
        tests_failed++;
        $display("FAIL pre_reset vec %0d: got %h want %h", i, obs_def, exp_v(i, i >= 25, 1, 1, 0));
      end
      if (i == 40) rst = 1'b1;
      tick();
    end
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tests_run++;
      if (obs_def !== 16'h0000) begin
        tests_failed++;
        $display("FAIL reset_mid_run cyc %0d: got %h want %h", c, obs_def, 16'h0000);
      end
      tick();
    end
  endtask

  task automatic test_edge_params();
    start_one = 1'b1;
    tick();
    start_one = 1'b0;
    tests_run++;
    if (obs_one !== exp_v(0, 1, 1, 1, 0)) begin
      tests_failed++;
      $display("FAIL one_vec: got %h want %h", obs_one, exp_v(0, 1, 1, 1, 0));
    end
    tick();
    tests_run++;
    if (obs_one !== exp_v(0, 1, 0, 0, 1)) begin
      tests_failed++;
      $display("FAIL one_done: got %h want %h", obs_one, exp_v(0, 1, 0, 0, 1));
    end
    tick();
    tests_run++;
    if (obs_one !== exp_v(0, 1, 0, 0, 0)) begin
      tests_failed++;
      $display("FAIL one_idle: got %h want %h", obs_one, exp_v(0, 1, 0, 0, 0));
    end

    start_nos = 1'b1;
    tick();
    start_nos = 1'b0;
    for (int i = 0; i <= 100; i++) begin
      tests_run++;
      if (obs_nos !== exp_v(i, 0, 1, 1, 0)) begin
        tests_failed++;
        $display("FAIL no_sel vec %0d: got %h want %h", i, obs_nos, exp_v(i, 0, 1, 1, 0));
      end
      tick();
    end
    tests_run++;
    if (obs_nos !== exp_v(100, 0, 0, 0, 1)) begin
      tests_failed++;
      $display("FAIL no_sel_done: got %h want %h", obs_nos, exp_v(100, 0, 0, 0, 1));
    end
  endtask

  initial begin
    rst       = 1'b1;
    start_def = 1'b0;
    start_div = 1'b0;
    start_one = 1'b0;
    start_nos = 1'b0;
    hold_def  = 1'b0;
    hold_div  = 1'b0;
    hold_one  = 1'b0;
    hold_nos  = 1'b0;
    #1;
    test_reset();
    test_default_run();
    test_hold_div();
    test_start_and_restart();
    test_reset_mid_run();
    test_edge_params();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_comb_stim_gen
